// File: rtl/sipo_pkg.sv
// sipo_pkg: shared definitions for the sipo_deser deserializer slice.
//   SIPO_LSB_FIRST / SIPO_MSB_FIRST : bit-order selectors for MSB_FIRST
//   sipo_width_ok()                 : legal-width predicate used at elaboration
package sipo_pkg;

    localparam bit SIPO_LSB_FIRST = 1'b0;
    localparam bit SIPO_MSB_FIRST = 1'b1;

    localparam int unsigned SIPO_MIN_WIDTH = 2;
    localparam int unsigned SIPO_MAX_WIDTH = 64;

    function automatic bit sipo_width_ok(input int unsigned width);
        return (width >= SIPO_MIN_WIDTH) && (width <= SIPO_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: shift register and word-boundary counter.
//   clk, rst_n    : clock, async active-low reset
//   clr           : synchronous clear back to reset state
//   serial_in     : serial data bit, accepted when serial_valid=1
//   bit_cnt       : bits accumulated toward the current word
//   complete      : combinational strobe, high when this edge completes a word
//   word          : next-state shift register value (the completed word)
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  bit          MSB_FIRST = SIPO_MSB_FIRST,
    localparam int unsigned CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic [CW-1:0]    bit_cnt,
    output logic             complete,
    output logic [WIDTH-1:0] word
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        complete  = 1'b0;
        if (clr) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (serial_valid) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], serial_in};
            end else begin
                shreg_d = {serial_in, shreg_q[WIDTH-1:1]};
            end
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                complete  = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The completed word includes the bit arriving on the completion edge.
    assign word    = shreg_d;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with output handshake.
//   clk, rst_n   : clock, async active-low reset
//   clr          : synchronous clear back to reset state
//   serial_in    : serial data bit, sampled when serial_valid=1
//   par_out      : holding register with the last completed word
//   par_valid    : par_out holds an unconsumed word
//   par_ready    : downstream accepts par_out this cycle
//   bit_cnt      : bits accumulated toward the current word
//   overrun      : sticky, a completed word was dropped
module sipo_deser
    import sipo_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  bit          MSB_FIRST = SIPO_MSB_FIRST,
    localparam int unsigned CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun
);

    if (!sipo_width_ok(WIDTH)) begin : g_bad_width
        $error("sipo_deser: WIDTH must be within 2..64");
    end

    logic             complete;
    logic [WIDTH-1:0] word;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .bit_cnt      (bit_cnt),
        .complete     (complete),
        .word         (word)
    );

    logic [WIDTH-1:0] par_out_q, par_out_d;
    logic             par_valid_q, par_valid_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        par_out_d   = par_out_q;
        par_valid_d = par_valid_q;
        overrun_d   = overrun_q;
        if (clr) begin
            par_out_d   = '0;
            par_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else if (complete) begin
            // A word may replace the held one only if that one is consumed now.
            if (!par_valid_q || par_ready) begin
                par_out_d   = word;
                par_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (par_valid_q && par_ready) begin
            par_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign par_out   = par_out_q;
    assign par_valid = par_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: drives one serial stream into an MSB-first and an LSB-first
// sipo_deser (WIDTH=8) and checks both against table and scoreboard values.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       serial_in;
    logic       serial_valid;
    logic       par_ready;

    logic [7:0] par_out_m, par_out_l;
    logic       par_valid_m, par_valid_l;
    logic [2:0] bit_cnt_m, bit_cnt_l;
    logic       overrun_m, overrun_l;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .par_out      (par_out_m),
        .par_valid    (par_valid_m),
        .par_ready    (par_ready),
        .bit_cnt      (bit_cnt_m),
        .overrun      (overrun_m)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .par_out      (par_out_l),
        .par_valid    (par_valid_l),
        .par_ready    (par_ready),
        .bit_cnt      (bit_cnt_l),
        .overrun      (overrun_l)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a transfer happens on the edge following a cycle with
    // par_valid && par_ready, so sample mid-cycle.
    always @(negedge clk) begin
        if (rst_n && par_valid_m && par_ready) begin
            if (q_m.size() == 0) check("sb_underflow_m", 64'(q_m.size()), 64'd1);
            else                 check("sb_word_m", par_out_m, q_m.pop_front());
        end
        if (rst_n && par_valid_l && par_ready) begin
            if (q_l.size() == 0) check("sb_underflow_l", 64'(q_l.size()), 64'd1);
            else                 check("sb_word_l", par_out_l, q_l.pop_front());
        end
    end

    // tx[7] is transmitted first.
    task automatic send_word(input logic [7:0] tx, input bit gapped,
                             input logic [7:0] em, input logic [7:0] el,
                             input bit push, input bit ready_on_last);
        for (int i = 7; i >= 0; i--) begin
            serial_in    = tx[i];
            serial_valid = 1'b1;
            if (i == 0) begin
                if (push) begin
                    q_m.push_back(em);
                    q_l.push_back(el);
                end
                if (ready_on_last) par_ready = 1'b1;
            end
            tick();
            serial_valid = 1'b0;
            if (i > 0) begin
                check("bit_cnt_m", bit_cnt_m, 64'(8 - i));
                check("bit_cnt_l", bit_cnt_l, 64'(8 - i));
                if (gapped && (i % 2 == 1)) begin
                    repeat (2) tick();
                    check("bit_cnt_hold", bit_cnt_m, 64'(8 - i));
                end
            end
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        bit         gapped;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{tx: 8'hC0, gapped: 1'b0, exp_m: 8'hC0, exp_l: 8'h03};
        vecs[1] = '{tx: 8'hA5, gapped: 1'b1, exp_m: 8'hA5, exp_l: 8'hA5};
        vecs[2] = '{tx: 8'h01, gapped: 1'b0, exp_m: 8'h01, exp_l: 8'h80};
        vecs[3] = '{tx: 8'hE4, gapped: 1'b1, exp_m: 8'hE4, exp_l: 8'h27};
        vecs[4] = '{tx: 8'h12, gapped: 1'b0, exp_m: 8'h12, exp_l: 8'h48};

        rst_n = 1'b0; clr = 1'b0; serial_in = 1'b0; serial_valid = 1'b0; par_ready = 1'b1;
        repeat (2) tick();
        check("rst_par_out",   par_out_m,   64'h0);
        check("rst_par_valid", par_valid_m, 64'h0);
        check("rst_bit_cnt",   bit_cnt_m,   64'h0);
        check("rst_overrun",   overrun_m,   64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table: continuous and gapped words, ready always high.
        foreach (vecs[k]) begin
            send_word(vecs[k].tx, vecs[k].gapped, vecs[k].exp_m, vecs[k].exp_l, 1'b1, 1'b0);
            check("tbl_valid_m", par_valid_m, 64'h1);
            check("tbl_out_m",   par_out_m,   vecs[k].exp_m);
            check("tbl_out_l",   par_out_l,   vecs[k].exp_l);
            check("tbl_cnt_wrap", bit_cnt_m,  64'h0);
            tick();
            check("tbl_pulse_m", par_valid_m, 64'h0);
            check("tbl_hold_m",  par_out_m,   vecs[k].exp_m);
        end

        // Overrun: second word dropped while first is held.
        par_ready = 1'b0;
        send_word(8'h3C, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0);
        send_word(8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        check("ovr_out_m",   par_out_m,   64'h3C);
        check("ovr_valid_m", par_valid_m, 64'h1);
        check("ovr_flag_m",  overrun_m,   64'h1);
        check("ovr_flag_l",  overrun_l,   64'h1);
        par_ready = 1'b1;
        tick();
        check("ovr_drain_valid", par_valid_m, 64'h0);
        check("ovr_sticky",      overrun_m,   64'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_overrun", overrun_m, 64'h0);
        check("clr_par_out", par_out_m, 64'h0);

        // Ready raised exactly on the completion edge of the next word.
        par_ready = 1'b0;
        send_word(8'h12, 1'b0, 8'h12, 8'h48, 1'b1, 1'b0);
        send_word(8'h34, 1'b0, 8'h34, 8'h2C, 1'b1, 1'b1);
        check("b2b_out_m",   par_out_m,   64'h34);
        check("b2b_out_l",   par_out_l,   64'h2C);
        check("b2b_valid_m", par_valid_m, 64'h1);
        check("b2b_overrun", overrun_m,   64'h0);
        tick();
        check("b2b_drain", par_valid_m, 64'h0);

        // Asynchronous reset in the middle of a word.
        for (int i = 0; i < 3; i++) begin
            serial_in = 1'b1; serial_valid = 1'b1;
            tick();
        end
        serial_valid = 1'b0;
        check("pre_rst_cnt", bit_cnt_m, 64'h3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_bit_cnt", bit_cnt_m, 64'h0);
        check("arst_par_out", par_out_m, 64'h0);
        check("arst_valid",   par_valid_m, 64'h0);
        check("arst_overrun", overrun_m, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_word(8'h5A, 1'b0, 8'h5A, 8'h5A, 1'b1, 1'b0);
        check("post_rst_out_m", par_out_m, 64'h5A);
        check("post_rst_out_l", par_out_l, 64'h5A);
        check("post_rst_valid", par_valid_m, 64'h1);
        repeat (2) tick();

        check("sb_drained_m", 64'(q_m.size()), 64'h0);
        check("sb_drained_l", 64'(q_l.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
